// File: rtl/cpu_defs.sv
// Shared CPU definitions: CP0 register indices, exception codes and the
// interrupt controller state encoding.
package cpu_defs;

    localparam logic [4:0] CP0_REG_COUNT   = 5'd9;
    localparam logic [4:0] CP0_REG_COMPARE = 5'd11;

    localparam logic [4:0] EXCCODE_INT = 5'd0;

    localparam int unsigned CAUSE_IP_W = 8;
    localparam int unsigned CAUSE_HW_W = 6;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_EXL = 2'd2
    } IrqCtrlState_t;

    // Count value after one tick, wrapping at 2^32.
    function automatic logic [31:0] count_next(input logic [31:0] cur);
        return cur + 32'd1;
    endfunction

endpackage

// File: rtl/cp0_irq_ctrl_timer.sv
// CP0 Count/Compare timer: clock divider, Count, Compare and the sticky
// timer-interrupt flag Cause.TI.
module cp0_timer
    import cpu_defs::*;
#(
    parameter int unsigned COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic [31:0] count_wdata,
    input  logic        compare_we,
    input  logic [31:0] compare_wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        cause_ti
);

    localparam int unsigned DivW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(COUNT_DIV - 1);

    logic [DivW-1:0] div_q, div_d;
    logic [31:0]     count_q, count_d;
    logic [31:0]     compare_q, compare_d;
    logic            ti_q, ti_d;
    logic            tick;
    logic [31:0]     count_inc;

    assign tick      = (div_q == DivLast);
    assign count_inc = count_next(count_q);

    always_comb begin
        div_d     = tick ? '0 : div_q + 1'b1;
        count_d   = count_q;
        compare_d = compare_q;
        ti_d      = ti_q;

        // A software load restarts the divider and never raises a match.
        if (count_we) begin
            count_d = count_wdata;
            div_d   = '0;
        end else if (tick) begin
            count_d = count_inc;
            if (count_inc == compare_q) begin
                ti_d = 1'b1;
            end
        end

        // Writing Compare acknowledges the timer, even over a same-cycle match.
        if (compare_we) begin
            compare_d = compare_wdata;
            ti_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q     <= '0;
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            div_q     <= div_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count    = count_q;
    assign compare  = compare_q;
    assign cause_ti = ti_q;

endmodule

// File: rtl/cp0_irq_ctrl.sv
// CP0 interrupt controller: hw_int synchronisers, software interrupt bits,
// Count/Compare timer and the req/ack handshake to the exception unit.
module cp0_irq_ctrl
    import cpu_defs::*;
#(
    parameter int unsigned HW_INT_NUM  = 6,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned COUNT_DIV   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [HW_INT_NUM-1:0] hw_int,
    input  logic                  sw_int_we,
    input  logic [1:0]            sw_int_wdata,
    input  logic                  count_we,
    input  logic [31:0]           count_wdata,
    input  logic                  compare_we,
    input  logic [31:0]           compare_wdata,
    input  logic                  status_ie,
    input  logic                  status_exl,
    input  logic                  status_erl,
    input  logic [7:0]            status_im,
    input  logic                  irq_ack,
    output logic [7:0]            cause_ip,
    output logic                  cause_ti,
    output logic [31:0]           count,
    output logic [31:0]           compare,
    output logic                  irq_req
);

    logic [HW_INT_NUM-1:0] sync_q [SYNC_STAGES];
    logic [1:0]            sw_ip_q;
    logic [CAUSE_HW_W-1:0] hw_ip;
    IrqCtrlState_t         state_q, state_d;
    logic                  cond;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= hw_int;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Lines beyond HW_INT_NUM read as zero in Cause.IP.
    for (genvar g = 0; g < int'(CAUSE_HW_W); g++) begin : g_hw_ip
        if (g < int'(HW_INT_NUM)) begin : g_used
            assign hw_ip[g] = sync_q[SYNC_STAGES-1][g];
        end else begin : g_unused
            assign hw_ip[g] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sw_ip_q <= 2'b00;
        end else if (sw_int_we) begin
            sw_ip_q <= sw_int_wdata;
        end
    end

    cp0_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk           (clk),
        .rst           (rst),
        .count_we      (count_we),
        .count_wdata   (count_wdata),
        .compare_we    (compare_we),
        .compare_wdata (compare_wdata),
        .count         (count),
        .compare       (compare),
        .cause_ti      (cause_ti)
    );

    assign cause_ip = {hw_ip[5] | cause_ti, hw_ip[4:0], sw_ip_q};

    assign cond = status_ie & ~status_exl & ~status_erl & (|(cause_ip & status_im));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (cond) state_d = REQ;
            end
            // An ack always wins, even if the source has just gone away.
            REQ: begin
                if (irq_ack)    state_d = WAIT_EXL;
                else if (!cond) state_d = IDLE;
            end
            // Hold off until the exception unit has raised EXL/ERL.
            WAIT_EXL: begin
                if (status_exl || status_erl) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign irq_req = (state_q == REQ);

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// Directed self-checking bench for cp0_irq_ctrl (HW_INT_NUM=6, SYNC_STAGES=2,
// COUNT_DIV=2).
module tb_cp0_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  hw_int;
    logic        sw_int_we;
    logic [1:0]  sw_int_wdata;
    logic        count_we;
    logic [31:0] count_wdata;
    logic        compare_we;
    logic [31:0] compare_wdata;
    logic        status_ie;
    logic        status_exl;
    logic        status_erl;
    logic [7:0]  status_im;
    logic        irq_ack;
    logic [7:0]  cause_ip;
    logic        cause_ti;
    logic [31:0] count;
    logic [31:0] compare;
    logic        irq_req;

    int checks = 0;
    int failures = 0;

    cp0_irq_ctrl #(
        .HW_INT_NUM  (6),
        .SYNC_STAGES (2),
        .COUNT_DIV   (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .hw_int        (hw_int),
        .sw_int_we     (sw_int_we),
        .sw_int_wdata  (sw_int_wdata),
        .count_we      (count_we),
        .count_wdata   (count_wdata),
        .compare_we    (compare_we),
        .compare_wdata (compare_wdata),
        .status_ie     (status_ie),
        .status_exl    (status_exl),
        .status_erl    (status_erl),
        .status_im     (status_im),
        .irq_ack       (irq_ack),
        .cause_ip      (cause_ip),
        .cause_ti      (cause_ti),
        .count         (count),
        .compare       (compare),
        .irq_req       (irq_req)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        hw_int = '0;
        sw_int_we = 1'b0;
        sw_int_wdata = '0;
        count_we = 1'b0;
        count_wdata = '0;
        compare_we = 1'b0;
        compare_wdata = '0;
        status_ie = 1'b0;
        status_exl = 1'b0;
        status_erl = 1'b0;
        status_im = '0;
        irq_ack = 1'b0;

        step(2);
        check("rst_count", count, 32'h0);
        check("rst_compare", compare, 32'h0);
        check("rst_ti", {31'b0, cause_ti}, 32'h0);
        check("rst_ip", {24'b0, cause_ip}, 32'h0);
        check("rst_req", {31'b0, irq_req}, 32'h0);

        rst = 1'b1;
        step(10);
        check("free_count", count, 32'd5);
        check("free_ip", {24'b0, cause_ip}, 32'h0);
        check("free_req", {31'b0, irq_req}, 32'h0);

        // Timer match
        compare_we = 1'b1; compare_wdata = 32'h10;
        count_we = 1'b1;   count_wdata = 32'h0E;
        step(1);
        compare_we = 1'b0; count_we = 1'b0;
        check("load_count", count, 32'h0E);
        check("load_compare", compare, 32'h10);
        step(3);
        check("pre_match_count", count, 32'h0F);
        check("pre_match_ti", {31'b0, cause_ti}, 32'h0);
        step(1);
        check("match_count", count, 32'h10);
        check("match_ti", {31'b0, cause_ti}, 32'h1);
        check("match_ip", {24'b0, cause_ip}, 32'h80);

        status_ie = 1'b1; status_im = 8'h80;
        step(1);
        check("timer_req", {31'b0, irq_req}, 32'h1);

        // Ack, then wait for EXL
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        check("ack_req_drop", {31'b0, irq_req}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("wait_exl_req", {31'b0, irq_req}, 32'h0);
        end
        status_exl = 1'b1;
        step(1);
        check("exl_req0", {31'b0, irq_req}, 32'h0);
        step(1);
        check("exl_req1", {31'b0, irq_req}, 32'h0);
        status_exl = 1'b0;
        step(1);
        check("rearm_req", {31'b0, irq_req}, 32'h1);
        check("ti_sticky", {31'b0, cause_ti}, 32'h1);

        compare_we = 1'b1; compare_wdata = 32'h1000;
        step(1);
        compare_we = 1'b0;
        check("cmp_clr_ti", {31'b0, cause_ti}, 32'h0);
        check("cmp_clr_ip", {24'b0, cause_ip}, 32'h0);
        step(1);
        check("withdraw_timer_req", {31'b0, irq_req}, 32'h0);

        // Hardware line through the synchroniser
        status_im = 8'h10;
        hw_int = 6'b000100;
        step(1);
        check("sync_lat1_ip", {24'b0, cause_ip}, 32'h0);
        step(1);
        check("sync_lat2_ip", {24'b0, cause_ip}, 32'h10);
        check("sync_lat2_req", {31'b0, irq_req}, 32'h0);
        step(1);
        check("hw_req", {31'b0, irq_req}, 32'h1);
        hw_int = '0;
        step(2);
        check("hw_drop_ip", {24'b0, cause_ip}, 32'h0);
        check("hw_drop_req_hold", {31'b0, irq_req}, 32'h1);
        step(1);
        check("hw_withdraw_req", {31'b0, irq_req}, 32'h0);
        step(1);
        check("hw_idle_req", {31'b0, irq_req}, 32'h0);

        // Count wrap and load-versus-tick priority
        count_we = 1'b1; count_wdata = 32'hFFFF_FFFF;
        step(1);
        count_we = 1'b0;
        check("wrap_load", count, 32'hFFFF_FFFF);
        step(1);
        check("wrap_hold", count, 32'hFFFF_FFFF);
        step(1);
        check("wrap_zero", count, 32'h0);
        step(1);
        count_we = 1'b1; count_wdata = 32'h1234;
        step(1);
        count_we = 1'b0;
        check("we_over_tick", count, 32'h1234);
        step(1);
        check("we_div_reset", count, 32'h1234);
        step(1);
        check("we_next_tick", count, 32'h1235);

        // Compare write on the same edge as a match
        compare_we = 1'b1; compare_wdata = 32'h1236;
        step(1);
        check("cmp_setup_ti", {31'b0, cause_ti}, 32'h0);
        step(1);
        compare_we = 1'b0;
        check("cmp_race_count", count, 32'h1236);
        check("cmp_race_ti", {31'b0, cause_ti}, 32'h0);
        count_we = 1'b1; count_wdata = 32'h1236;
        step(1);
        count_we = 1'b0;
        check("load_eq_cmp_ti", {31'b0, cause_ti}, 32'h0);

        // Software interrupt, then reset while requesting
        status_im = 8'h01;
        sw_int_we = 1'b1; sw_int_wdata = 2'b01;
        step(1);
        sw_int_we = 1'b0;
        check("sw_ip", {24'b0, cause_ip}, 32'h01);
        step(1);
        check("sw_req", {31'b0, irq_req}, 32'h1);
        rst = 1'b0;
        step(1);
        check("mid_rst_req", {31'b0, irq_req}, 32'h0);
        check("mid_rst_count", count, 32'h0);
        check("mid_rst_ip", {24'b0, cause_ip}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
